sdram_init_seq: RTL and testbench

Parametrised SDRAM power-up and initialisation sequencer. It drives the command and address buses from reset until the device is ready: power-up wait, PRECHARGE ALL, N auto-refreshes, then LOAD MODE REGISTER. All timing intervals, the refresh count and the mode-register fields are parameters. A re-initialisation request lets the controller rerun the sequence, without the power-up wait, after the device has been ready. The block sits beside the refresh/read/write engines; the top-level arbiter grants nothing until `init_done`.

---
 rtl/sdram_pkg.sv | 37 +++
 rtl/sdram_init_seq.sv | 163 ++++++++++++++++
 tb/tb_sdram_init_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Purpose: shared SDRAM command encodings and mode-register field positions.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
//
// Commands are {cs_n, ras_n, cas_n, we_n}. The refresh and read/write engines
// use the same encodings, so this package is the single source for them.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PALL = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    // Mode-register field positions on the address bus during MRS.
    localparam int MRS_BL_LSB = 0;   // burst length, 3 bits
    localparam int MRS_BT_BIT = 3;   // burst type
    localparam int MRS_CL_LSB = 4;   // CAS latency, 3 bits
    localparam int MRS_WB_BIT = 9;   // write burst mode

    // A10: "all banks" on PRECHARGE, auto-precharge on READ/WRITE.
    localparam int ADDR_AP_BIT = 10;

    // Low 11 address bits of an MRS command; unused bits stay 0.
    function automatic logic [10:0] mrs_word(input logic [2:0] bl,
                                             input logic       bt,
                                             input logic [2:0] cl,
                                             input logic       wb);
        logic [10:0] w;
        w                     = '0;
        w[MRS_BL_LSB +: 3]    = bl;
        w[MRS_BT_BIT]         = bt;
        w[MRS_CL_LSB +: 3]    = cl;
        w[MRS_WB_BIT]         = wb;
        return w;
    endfunction

endpackage

// File: rtl/sdram_init_seq.sv
// Purpose: SDRAM power-up/initialisation sequencer (wait, PALL, N x AREF, MRS).
// Latency: PALL at T_POWERUP cycles after reset release; ready T_RP+REF_NUM*T_RFC+T_MRD later.
// Backpressure: none; reinit_req is a one-cycle request, honoured only in DONE, never queued.
//
// Ports: clk, rst_n (async active-low), reinit_req (rerun without power-up wait),
//        cmd {cs_n,ras_n,cas_n,we_n} and addr (registered), ba (always 0),
//        init_done (level), init_done_pulse (one cycle on each rise of init_done).
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int         T_POWERUP  = 10000,
    parameter int         T_RP       = 2,
    parameter int         T_RFC      = 7,
    parameter int         T_MRD      = 2,
    parameter int         REF_NUM    = 2,
    parameter int         ADDR_W     = 13,
    parameter logic [2:0] BURST_LEN  = 3'b010,
    parameter logic       BURST_TYPE = 1'b0,
    parameter logic [2:0] CAS_LAT    = 3'b011,
    parameter logic       WR_BURST   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reinit_req,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        ba,
    output logic              init_done,
    output logic              init_done_pulse
);

    generate
        if (T_POWERUP < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1 ||
            REF_NUM < 1 || REF_NUM > 15 || ADDR_W < 11) begin : g_bad_param
            $fatal(1, "sdram_init_seq: illegal parameter value");
        end
    endgenerate

    localparam int MAX_A = (T_POWERUP > T_RP)  ? T_POWERUP : T_RP;
    localparam int MAX_B = (T_RFC > T_MRD)     ? T_RFC     : T_MRD;
    localparam int MAX_T = (MAX_A > MAX_B)     ? MAX_A     : MAX_B;
    localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(1) << ADDR_AP_BIT;
    localparam logic [ADDR_W-1:0] ADDR_MRS  =
        ADDR_W'(mrs_word(BURST_LEN, BURST_TYPE, CAS_LAT, WR_BURST));

    typedef enum logic [2:0] {
        S_WAIT_PWR,
        S_PRECHARGE,
        S_WAIT_RP,
        S_REFRESH,
        S_WAIT_RFC,
        S_LOAD_MODE,
        S_WAIT_MRD,
        S_DONE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    ref_cnt;
    // Timer is cleared by reset, so the power-up interval is loaded on the
    // first clock of WAIT_PWR; this flag marks that load as done.
    logic          pwr_armed;

    // The command register is issued in the cycle a state is entered, so the
    // timer is loaded with interval-1: the next command lands exactly
    // 'interval' cycles later (a 1-cycle interval means back-to-back).
    function automatic logic [TW-1:0] ld(input int t);
        return TW'(t - 1);
    endfunction

    assign ba = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_WAIT_PWR;
            timer           <= '0;
            ref_cnt         <= '0;
            pwr_armed       <= 1'b0;
            cmd             <= CMD_NOP;
            addr            <= ADDR_IDLE;
            init_done       <= 1'b0;
            init_done_pulse <= 1'b0;
        end else begin
            cmd             <= CMD_NOP;
            addr            <= ADDR_IDLE;
            init_done_pulse <= 1'b0;

            case (state)
                S_WAIT_PWR: begin
                    if (!pwr_armed) begin
                        pwr_armed <= 1'b1;
                        timer     <= ld(T_POWERUP);
                    end else if (timer == '0) begin
                        state   <= S_PRECHARGE;
                        cmd     <= CMD_PALL;
                        timer   <= ld(T_RP);
                        ref_cnt <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                S_PRECHARGE, S_WAIT_RP: begin
                    if (timer == '0) begin
                        state   <= S_REFRESH;
                        cmd     <= CMD_AREF;
                        timer   <= ld(T_RFC);
                        ref_cnt <= ref_cnt + 1'b1;
                    end else begin
                        state <= S_WAIT_RP;
                        timer <= timer - 1'b1;
                    end
                end

                S_REFRESH, S_WAIT_RFC: begin
                    if (timer != '0) begin
                        state <= S_WAIT_RFC;
                        timer <= timer - 1'b1;
                    end else if (ref_cnt == 4'(REF_NUM)) begin
                        state <= S_LOAD_MODE;
                        cmd   <= CMD_MRS;
                        addr  <= ADDR_MRS;
                        timer <= ld(T_MRD);
                    end else begin
                        state   <= S_REFRESH;
                        cmd     <= CMD_AREF;
                        timer   <= ld(T_RFC);
                        ref_cnt <= ref_cnt + 1'b1;
                    end
                end

                S_LOAD_MODE, S_WAIT_MRD: begin
                    if (timer == '0) begin
                        state           <= S_DONE;
                        init_done       <= 1'b1;
                        init_done_pulse <= 1'b1;
                    end else begin
                        state <= S_WAIT_MRD;
                        timer <= timer - 1'b1;
                    end
                end

                S_DONE: begin
                    // Re-init skips the power-up wait and drops ready with the PALL.
                    if (reinit_req) begin
                        state     <= S_PRECHARGE;
                        cmd       <= CMD_PALL;
                        timer     <= ld(T_RP);
                        ref_cnt   <= '0;
                        init_done <= 1'b0;
                    end
                end

                default: begin
                    state <= S_WAIT_PWR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Purpose: self-checking bench for sdram_init_seq (default and a short-timing instance).
// Latency: expected schedule is derived from the PALL cycle of each run.
// Backpressure: n/a.
module tb_sdram_init_seq;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PALL = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MRS  = 4'b0000;

    // Instance A: default parameters.
    localparam int A_PWR = 10000, A_RP = 2, A_RFC = 7, A_MRD = 2, A_NREF = 2;
    localparam logic [12:0] A_MRS_ADDR = 13'h0032;
    // Instance B: short power-up, many refreshes, CL2, BL8.
    localparam int B_PWR = 20, B_RP = 3, B_RFC = 5, B_MRD = 2, B_NREF = 8;
    localparam logic [12:0] B_MRS_ADDR = 13'h0023;

    localparam logic [12:0] IDLE_ADDR = 13'h0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reinit_a = 1'b0;
    logic        reinit_b = 1'b0;
    logic [3:0]  cmd_a, cmd_b;
    logic [12:0] addr_a, addr_b;
    logic [1:0]  ba_a, ba_b;
    logic        done_a, done_b, pulse_a, pulse_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: cycle of the current run's PALL, and whether
    // init_done is expected high before that PALL (a re-init run).
    int base_a, base_b;
    bit hold_a, hold_b;
    // Scheduled request cycles (-1 = none): "ign" lands outside DONE, "go" in DONE.
    int ra_ign, ra_go, rb_ign, rb_go;

    always #5 clk = ~clk;

    sdram_init_seq dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .reinit_req      (reinit_a),
        .cmd             (cmd_a),
        .addr            (addr_a),
        .ba              (ba_a),
        .init_done       (done_a),
        .init_done_pulse (pulse_a)
    );

    sdram_init_seq #(
        .T_POWERUP (B_PWR),
        .T_RP      (B_RP),
        .T_RFC     (B_RFC),
        .T_MRD     (B_MRD),
        .REF_NUM   (B_NREF),
        .CAS_LAT   (3'b010),
        .BURST_LEN (3'b011)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .reinit_req      (reinit_b),
        .cmd             (cmd_b),
        .addr            (addr_b),
        .ba              (ba_b),
        .init_done       (done_b),
        .init_done_pulse (pulse_b)
    );

    // Expected outputs at absolute cycle c for a run whose PALL is at 'base'.
    function automatic void model(input int c, input int base, input bit hold,
                                  input int trp, input int trfc, input int nref,
                                  input int tmrd,
                                  output logic [3:0] e_cmd, output logic e_done,
                                  output logic e_pulse);
        int k, m;
        k = c - base;
        m = trp + nref * trfc;
        e_cmd   = NOP;
        e_done  = hold;
        e_pulse = 1'b0;
        if (k >= 0) begin
            if (k == 0)
                e_cmd = PALL;
            else if (k == m)
                e_cmd = MRS;
            else if (k >= trp && k < m && ((k - trp) % trfc) == 0)
                e_cmd = AREF;
            e_done  = (k >= m + tmrd);
            e_pulse = (k == m + tmrd);
        end
    endfunction

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk13(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [3:0] o_cmd, input logic [12:0] o_addr,
                           input logic [1:0] o_ba, input logic o_done, input logic o_pulse,
                           input logic [3:0] e_cmd, input logic [12:0] e_addr,
                           input logic e_done, input logic e_pulse);
        chk4({tag, "_cmd"}, o_cmd, e_cmd);
        chk13({tag, "_addr"}, o_addr, e_addr);
        chk4({tag, "_ba"}, {2'b00, o_ba}, 4'h0);
        chk4({tag, "_done"}, {3'b000, o_done}, {3'b000, e_done});
        chk4({tag, "_pulse"}, {3'b000, o_pulse}, {3'b000, e_pulse});
    endtask

    task automatic check_reset(input string tag);
        chk_all({tag, "_a"}, cmd_a, addr_a, ba_a, done_a, pulse_a, NOP, IDLE_ADDR, 1'b0, 1'b0);
        chk_all({tag, "_b"}, cmd_b, addr_b, ba_b, done_b, pulse_b, NOP, IDLE_ADDR, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        base_a = A_PWR; hold_a = 1'b0;
        base_b = B_PWR; hold_b = 1'b0;
        ra_ign = -1; ra_go = -1; rb_ign = -1; rb_go = -1;
        cyc = 0;
    endtask

    // One clock: sample away from the edge, compare both instances, drive requests.
    task automatic step();
        logic [3:0] ec;
        logic       ed, ep;
        @(posedge clk);
        #1;
        reinit_a = 1'b0;
        reinit_b = 1'b0;
        model(cyc, base_a, hold_a, A_RP, A_RFC, A_NREF, A_MRD, ec, ed, ep);
        chk_all("a", cmd_a, addr_a, ba_a, done_a, pulse_a,
                ec, (ec == MRS) ? A_MRS_ADDR : IDLE_ADDR, ed, ep);
        model(cyc, base_b, hold_b, B_RP, B_RFC, B_NREF, B_MRD, ec, ed, ep);
        chk_all("b", cmd_b, addr_b, ba_b, done_b, pulse_b,
                ec, (ec == MRS) ? B_MRS_ADDR : IDLE_ADDR, ed, ep);
        if (cyc == ra_ign) reinit_a = 1'b1;
        if (cyc == rb_ign) reinit_b = 1'b1;
        if (cyc == ra_go) begin
            reinit_a = 1'b1; base_a = cyc + 1; hold_a = 1'b1;
        end
        if (cyc == rb_go) begin
            reinit_b = 1'b1; base_b = cyc + 1; hold_b = 1'b1;
        end
        cyc++;
    endtask

    task automatic run_to(input int last);
        while (cyc <= last) step();
    endtask

    // Assert reset mid-cycle, confirm the asynchronous return, hold, release.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset({tag, "_async"});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset({tag, "_held"});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int rst_at;

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Run 1: full sequence on both, ignored requests outside DONE,
        // then a re-init from DONE on each instance.
        ra_ign = $urandom_range(10008, 10003);    // A in WAIT_RFC
        ra_go  = $urandom_range(10030, 10018);
        rb_ign = $urandom_range(63, 21);
        rb_go  = $urandom_range(90, 65);
        run_to(10060);

        // Reset while both are in DONE: full power-up wait repeats.
        pulse_reset("rst_done");
        rst_at = $urandom_range(10008, 10003);    // between A's AREFs
        run_to(rst_at);

        // Reset mid-sequence, then a clean uninterrupted run.
        pulse_reset("rst_mid");
        run_to(10040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
